// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP multiplier back end.
// Covers round modes, status bit positions, special-value encodings and operand classification.
package fp_mult_pkg;

    typedef enum logic [2:0] {
        RND_NE = 3'b000,
        RND_TZ = 3'b001,
        RND_UP = 3'b010,
        RND_DN = 3'b011,
        RND_NU = 3'b100,
        RND_AZ = 3'b101
    } round_mode_e;

    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_NAN     = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;

    localparam logic [31:0] CANON_NAN      = 32'h7FC00000;
    localparam logic [30:0] MAX_NORMAL_MAG = 31'h7F7FFFFF;
    localparam logic [30:0] MIN_NORMAL_MAG = 31'h00800000;
    localparam logic [7:0]  EXP_ALL_ONES   = 8'hFF;

    typedef struct packed {
        logic isNan;
        logic isInf;
        logic isZero;
    } op_class_t;

    typedef struct packed {
        logic        isNan;
        logic        isInf;
        logic        isZero;
        logic        sign;
        logic        huge;
        logic        tiny;
        logic        inexact;
        logic [7:0]  expField;
        logic [22:0] mant;
        round_mode_e mode;
    } s1_payload_t;

    // Reserved encodings 110/111 fold onto round-to-nearest-even.
    function automatic round_mode_e normRnd(input logic [2:0] rnd);
        return (rnd > 3'b101) ? RND_NE : round_mode_e'(rnd);
    endfunction

    function automatic logic roundsOutward(input round_mode_e mode, input logic sign);
        return (mode == RND_AZ) || ((mode == RND_UP) && !sign) || ((mode == RND_DN) && sign);
    endfunction

    // Subnormals classify as zero.
    function automatic op_class_t classify(input logic [30:0] mag);
        op_class_t c;
        c.isNan  = (mag[30:23] == EXP_ALL_ONES) && (mag[22:0] != 23'h0);
        c.isInf  = (mag[30:23] == EXP_ALL_ONES) && (mag[22:0] == 23'h0);
        c.isZero = (mag[30:23] == 8'h00);
        return c;
    endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational mantissa rounder: applies the selected round mode to {1,mant}
// and reports the carry out of the hidden bit plus inexactness.
module fp_round
    import fp_mult_pkg::*;
(
    input  logic [2:0]  i_rnd,
    input  logic        i_sign,
    input  logic [22:0] i_mant,
    input  logic        i_guard,
    input  logic        i_sticky,
    output logic [22:0] o_mant,
    output logic        o_carry,
    output logic        o_inexact
);

    round_mode_e w_mode;
    logic        w_inexact;
    logic        w_roundUp;
    logic        w_unusedLead;

    always_comb begin
        w_mode    = normRnd(i_rnd);
        w_inexact = i_guard | i_sticky;
        case (w_mode)
            RND_NE:  w_roundUp = i_guard & (i_sticky | i_mant[0]);
            RND_TZ:  w_roundUp = 1'b0;
            RND_NU:  w_roundUp = i_guard;
            default: w_roundUp = roundsOutward(w_mode, i_sign) & w_inexact;
        endcase
    end

    // On carry the sum is exactly 1_0000..0, so the fraction is already cleared.
    assign {o_carry, w_unusedLead, o_mant} = {2'b01, i_mant} + {24'h0, w_roundUp};
    assign o_inexact = w_inexact;

endmodule

// File: rtl/fp_round_exc.sv
// Two-stage elastic round/exception/pack back end for single-precision multiply.
// Define STICKY_STATUS_EN to add the sticky_clr input and accumulated sticky_status output.
module fp_round_exc
    import fp_mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign_p,
    input  logic [9:0]  exp_p,
    input  logic [22:0] mant_p,
    input  logic        guard,
    input  logic        sticky,
    input  logic [2:0]  rnd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic [7:0]  status
`ifdef STICKY_STATUS_EN
    ,
    input  logic        sticky_clr,
    output logic [7:0]  sticky_status
`endif
);

    op_class_t          w_aCls;
    op_class_t          w_bCls;
    logic [22:0]        w_rndMant;
    logic               w_carry;
    logic               w_inexact;
    logic               w_nearCarry;
    logic signed [10:0] w_expRnd;
    logic signed [10:0] w_expNear;
    logic               w_unusedSigns;
    s1_payload_t        w_s1Next;
    s1_payload_t        r_s1;
    logic               r_s1Valid;
    logic               r_s2Valid;
    logic [31:0]        r_z;
    logic [7:0]         r_status;
    logic [31:0]        w_zNext;
    logic [7:0]         w_statusNext;
    logic               w_s2Free;
    logic               w_s1Load;

    assign w_aCls        = classify(a[30:0]);
    assign w_bCls        = classify(b[30:0]);
    assign w_unusedSigns = a[31] ^ b[31];

    fp_round u_round (
        .i_rnd     (rnd),
        .i_sign    (sign_p),
        .i_mant    (mant_p),
        .i_guard   (guard),
        .i_sticky  (sticky),
        .o_mant    (w_rndMant),
        .o_carry   (w_carry),
        .o_inexact (w_inexact)
    );

    // Overflow also triggers when the exact value reaches the round-to-nearest
    // threshold, so truncating modes still flag huge and saturate to max-normal.
    assign w_nearCarry = (&mant_p) & guard;
    assign w_expRnd    = $signed({exp_p[9], exp_p}) + $signed({10'h0, w_carry});
    assign w_expNear   = $signed({exp_p[9], exp_p}) + $signed({10'h0, w_nearCarry});

    always_comb begin
        w_s1Next          = '0;
        w_s1Next.isNan    = w_aCls.isNan | w_bCls.isNan
                          | (w_aCls.isZero & w_bCls.isInf) | (w_aCls.isInf & w_bCls.isZero);
        w_s1Next.isInf    = w_aCls.isInf | w_bCls.isInf;
        w_s1Next.isZero   = w_aCls.isZero | w_bCls.isZero;
        w_s1Next.sign     = sign_p;
        w_s1Next.huge     = (w_expRnd >= 11'sd255) || (w_expNear >= 11'sd255);
        w_s1Next.tiny     = (w_expRnd <= 11'sd0);
        w_s1Next.inexact  = w_inexact;
        w_s1Next.expField = w_expRnd[7:0];
        w_s1Next.mant     = w_rndMant;
        w_s1Next.mode     = normRnd(rnd);
    end

    assign w_s2Free = ~r_s2Valid | out_ready;
    assign in_ready = ~r_s1Valid | w_s2Free;
    assign w_s1Load = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1      <= '0;
        end else begin
            if (in_ready) r_s1Valid <= in_valid;
            if (w_s1Load) r_s1 <= w_s1Next;
        end
    end

    always_comb begin
        w_zNext      = '0;
        w_statusNext = '0;
        if (r_s1.isNan) begin
            w_zNext              = CANON_NAN;
            w_statusNext[ST_NAN] = 1'b1;
        end else if (r_s1.isInf) begin
            w_zNext              = {r_s1.sign, EXP_ALL_ONES, 23'h0};
            w_statusNext[ST_INF] = 1'b1;
        end else if (r_s1.isZero) begin
            w_zNext               = {r_s1.sign, 31'h0};
            w_statusNext[ST_ZERO] = 1'b1;
        end else if (r_s1.huge) begin
            w_statusNext[ST_HUGE]    = 1'b1;
            w_statusNext[ST_INEXACT] = 1'b1;
            if ((r_s1.mode == RND_NE) || (r_s1.mode == RND_NU) || roundsOutward(r_s1.mode, r_s1.sign)) begin
                w_zNext              = {r_s1.sign, EXP_ALL_ONES, 23'h0};
                w_statusNext[ST_INF] = 1'b1;
            end else begin
                w_zNext = {r_s1.sign, MAX_NORMAL_MAG};
            end
        end else if (r_s1.tiny) begin
            w_statusNext[ST_TINY]    = 1'b1;
            w_statusNext[ST_INEXACT] = 1'b1;
            if (roundsOutward(r_s1.mode, r_s1.sign)) begin
                w_zNext = {r_s1.sign, MIN_NORMAL_MAG};
            end else begin
                w_zNext               = {r_s1.sign, 31'h0};
                w_statusNext[ST_ZERO] = 1'b1;
            end
        end else begin
            w_zNext                  = {r_s1.sign, r_s1.expField, r_s1.mant};
            w_statusNext[ST_INEXACT] = r_s1.inexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2Valid <= 1'b0;
            r_z       <= '0;
            r_status  <= '0;
        end else if (w_s2Free) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_z      <= w_zNext;
                r_status <= w_statusNext;
            end
        end
    end

    assign out_valid = r_s2Valid;
    assign z         = r_z;
    assign status    = r_status;

`ifdef STICKY_STATUS_EN
    logic [7:0] r_stickyStatus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stickyStatus <= '0;
        end else if (sticky_clr) begin
            r_stickyStatus <= '0;
        end else if (r_s2Valid && out_ready) begin
            r_stickyStatus <= r_stickyStatus | r_status;
        end
    end

    assign sticky_status = r_stickyStatus;
`endif

endmodule
